// File: rtl/branch_redirect_ctrl.sv
// Branch/jump prediction recovery for the 5-stage RV32I pipeline: tracks ID predictions in order,
// checks them against EX resolution, drives redirect and flushes. Optional macro: BRANCH_PERF_CNT_EN.
module branch_redirect_ctrl #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_push,
  input  logic [31:0] id_pc,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_pc,
  input  logic        stall_in,
  input  logic        ex_resolve,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic [31:0] ex_pc4,
  output logic        stall_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        sync_err
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispred
`endif
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FCNT_W = 3;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [FCNT_W-1:0] FLUSH_LEN = FCNT_W'(FLUSH_CYCLES);

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } entry_t;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state;
  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [FCNT_W-1:0] flush_cnt;

  logic full;
  logic in_idle;
  logic push_ok;
  logic pop_ok;
  logic orphan;
  logic tag_err;
  logic mispredict;

  // Push/pop qualification and head comparison against the EX outcome
  always_comb begin
    full       = (count == FULL_CNT);
    in_idle    = (state == IDLE);
    stall_out  = full & id_push;
    push_ok    = id_push & ~stall_in & ~full & in_idle;
    pop_ok     = ex_resolve & in_idle & (count != '0);
    orphan     = ex_resolve & in_idle & (count == '0);
    head       = mem[rd_ptr];
    tag_err    = (head.pc != ex_pc);
    mispredict = pop_ok & ((head.pred_taken != ex_taken) |
                           (ex_taken & (head.pred_pc != ex_target)) |
                           tag_err);
  end

  // Entry storage needs no reset: validity is carried by count
  always_ff @(posedge clk) begin
    if (push_ok && !mispredict) begin
      mem[wr_ptr] <= '{pc: id_pc, pred_taken: id_pred_taken, pred_pc: id_pred_pc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      sync_err       <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      if (state == IDLE) begin
        if (orphan || (pop_ok && tag_err)) begin
          sync_err <= 1'b1;
        end
        if (mispredict) begin
          // Younger entries and any same-cycle push are wrong-path: drop everything
          redirect_valid <= 1'b1;
          redirect_pc    <= ex_taken ? ex_target : ex_pc4;
          wr_ptr         <= '0;
          rd_ptr         <= '0;
          count          <= '0;
          state          <= FLUSH;
          flush_cnt      <= FLUSH_LEN;
          flush_if_id    <= 1'b1;
          flush_id_ex    <= 1'b1;
        end else begin
          if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
          if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
          case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
          endcase
        end
      end else begin
        if (flush_cnt <= FCNT_W'(1)) begin
          state       <= IDLE;
          flush_cnt   <= '0;
          flush_if_id <= 1'b0;
          flush_id_ex <= 1'b0;
        end else begin
          flush_cnt <= flush_cnt - FCNT_W'(1);
        end
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  // pop_ok and mispredict are already gated to IDLE, so FLUSH never counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches <= 32'h0;
      perf_mispred  <= 32'h0;
    end else begin
      if (pop_ok)     perf_branches <= perf_branches + 32'd1;
      if (mispredict) perf_mispred  <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized + directed bench for branch_redirect_ctrl against a queue-based prediction model.
module tb_branch_redirect_ctrl;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic        clk;
  logic        rst_n;
  logic        id_push;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic [31:0] id_pred_pc;
  logic        stall_in;
  logic        ex_resolve;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pc4;
  logic        stall_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        sync_err;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;
`endif

  branch_redirect_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_push        (id_push),
    .id_pc          (id_pc),
    .id_pred_taken  (id_pred_taken),
    .id_pred_pc     (id_pred_pc),
    .stall_in       (stall_in),
    .ex_resolve     (ex_resolve),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pc4         (ex_pc4),
    .stall_out      (stall_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .sync_err       (sync_err)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ppc;
  } ent_t;

  // Reference model: outstanding predictions, oldest first
  ent_t        q[$];
  int          m_flush_left;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic        m_serr;
  logic [31:0] m_pb;
  logic [31:0] m_pm;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_flush_left = 0;
    m_rv   = 1'b0;
    m_rpc  = 32'h0;
    m_serr = 1'b0;
    m_pb   = 32'h0;
    m_pm   = 32'h0;
  endtask

  task automatic check_outputs();
    check_eq("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    check_eq("redirect_pc", redirect_pc, m_rpc);
    check_eq("flush_if_id", 32'(flush_if_id), 32'(m_flush_left > 0));
    check_eq("flush_id_ex", 32'(flush_id_ex), 32'(m_flush_left > 0));
    check_eq("sync_err", 32'(sync_err), 32'(m_serr));
`ifdef BRANCH_PERF_CNT_EN
    check_eq("perf_branches", perf_branches, m_pb);
    check_eq("perf_mispred", perf_mispred, m_pm);
`endif
  endtask

  // One pipeline cycle: drive at negedge, check combinational stall, advance model, check after edge
  task automatic drive_cycle(input logic push, input logic [31:0] pc, input logic pt,
                             input logic [31:0] ppc, input logic stl, input logic res,
                             input logic [31:0] epc, input logic etk, input logic [31:0] etgt);
    bit   mis;
    bit   popped;
    ent_t h;
    int   sz;
    @(negedge clk);
    id_push = push; id_pc = pc; id_pred_taken = pt; id_pred_pc = ppc; stall_in = stl;
    ex_resolve = res; ex_pc = epc; ex_taken = etk; ex_target = etgt; ex_pc4 = epc + 32'd4;
    #1;
    sz = q.size();
    check_eq("stall_out", 32'(stall_out), 32'((sz == DEPTH) && push));
    m_rv = 1'b0;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      mis = 1'b0;
      popped = 1'b0;
      if (res) begin
        if (sz == 0) begin
          m_serr = 1'b1;
        end else begin
          h = q[0];
          popped = 1'b1;
          m_pb++;
          if (h.pc != epc) m_serr = 1'b1;
          mis = (h.pt != etk) || (etk && h.ppc != etgt) || (h.pc != epc);
        end
      end
      if (mis) begin
        q.delete();
        m_rv = 1'b1;
        m_rpc = etk ? etgt : epc + 32'd4;
        m_flush_left = FLUSH_CYCLES;
        m_pm++;
      end else begin
        if (popped) void'(q.pop_front());
        if (push && !stl && sz < DEPTH) q.push_back('{pc: pc, pt: pt, ppc: ppc});
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_only(input logic [31:0] pc, input logic pt, input logic [31:0] ppc);
    drive_cycle(1, pc, pt, ppc, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve_only(input logic [31:0] epc, input logic etk, input logic [31:0] etgt);
    drive_cycle(0, 0, 0, 0, 0, 1, epc, etk, etgt);
  endtask

  // Asynchronous reset asserted away from any clock edge; outputs must clear immediately
  task automatic do_reset();
    #2;
    id_push = 1'b0; ex_resolve = 1'b0; stall_in = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_eq("rst_stall_out", 32'(stall_out), 32'h0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    logic        push, pt, stl, res, etk;
    logic [31:0] pc, ppc, epc, etgt;
    for (int i = 0; i < n; i++) begin
      push = ($urandom_range(0, 99) < 55);
      pc   = {$urandom_range(0, 32'h3FFF), 2'b00};
      pt   = $urandom_range(0, 1);
      ppc  = pt ? {$urandom_range(0, 32'h3FFF), 2'b00} : pc + 32'd4;
      stl  = ($urandom_range(0, 99) < 15);
      res  = ($urandom_range(0, 99) < 40);
      epc  = {$urandom_range(0, 32'h3FFF), 2'b00};
      etk  = $urandom_range(0, 1);
      etgt = {$urandom_range(0, 32'h3FFF), 2'b00};
      if (q.size() > 0 && $urandom_range(0, 99) < 80) begin
        epc  = q[0].pc;
        etk  = q[0].pt;
        etgt = q[0].pt ? q[0].ppc : etgt;
        if ($urandom_range(0, 99) < 15) etk = ~etk;
        else if ($urandom_range(0, 99) < 10) etgt = etgt + 32'd8;
      end
      drive_cycle(push, pc, pt, ppc, stl, res, epc, etk, etgt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    id_push = 0; id_pc = 0; id_pred_taken = 0; id_pred_pc = 0; stall_in = 0;
    ex_resolve = 0; ex_pc = 0; ex_taken = 0; ex_target = 0; ex_pc4 = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall_out", 32'(stall_out), 32'h0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Correct not-taken branch
    push_only(32'h100, 0, 32'h104);
    idle_cycles(1);
    resolve_only(32'h100, 0, 32'h900);
    idle_cycles(1);

    // Mispredicted branch: actually taken
    push_only(32'h200, 0, 32'h204);
    resolve_only(32'h200, 1, 32'h1F0);
    idle_cycles(3);

    // JALR with wrong predicted target
    push_only(32'h300, 1, 32'h400);
    resolve_only(32'h300, 1, 32'h480);
    idle_cycles(3);

    // Fill, overflow push, then steady push+pop across pointer wrap
    for (int i = 0; i < 4; i++) push_only(32'h1000 + 32'(i * 4), 0, 32'h1004 + 32'(i * 4));
    push_only(32'h2000, 1, 32'h3000);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 32'h1100 + 32'(i * 4), 0, 32'h1104 + 32'(i * 4), 0,
                  1, q[0].pc, q[0].pt, q[0].ppc);
    end
    for (int i = 0; i < 4; i++) resolve_only(q[0].pc, q[0].pt, q[0].ppc);
    push_only(32'h1200, 0, 32'h1204);
    resolve_only(32'h1200, 0, 32'h0);

    // Tag mismatch, then reset in the middle of the resulting flush
    push_only(32'h500, 0, 32'h504);
    push_only(32'h600, 0, 32'h604);
    push_only(32'h700, 1, 32'h800);
    resolve_only(32'h504, 0, 32'h0);
    do_reset();
    push_only(32'h900, 0, 32'h904);
    resolve_only(32'h900, 0, 32'h0);

    // Orphan resolve
    resolve_only(32'hA00, 1, 32'hB00);
    idle_cycles(2);

    do_reset();
    random_cycles(400);
    do_reset();
    random_cycles(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
